// File: rtl/div_real_seq_pkg.sv
// Shared types and elaboration-time helpers for the sequential svreal divider.
// Widths and alignment shift are derived here so wrapper and bench agree.
package svreal_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left shift applied to |a| so the integer quotient lands on c's exponent.
  function automatic int calc_shift(input int a_exp, input int b_exp, input int c_exp);
    return a_exp - b_exp - c_exp;
  endfunction

  function automatic int calc_nw(input int width, input int shift);
    return width + shift;
  endfunction

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/div_real_seq_if.sv
// Operand/result bundle between a producer/consumer and the divider.
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high; the source holds valid and payload until then, and ready never waits on valid.
interface div_real_seq_if #(
  parameter int a_width = 16,
  parameter int b_width = 17,
  parameter int c_width = 18
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [a_width-1:0] a;
  logic signed [b_width-1:0] b;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [c_width-1:0] c;
  logic                      div_by_zero;
  logic                      overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, div_by_zero, overflow
  );
endinterface

// File: rtl/div_real_seq_core.sv
// Unsigned restoring divider: one quotient bit per clock after start,
// single-cycle done pulse once all nw numerator bits have been consumed.
module div_real_core #(
  parameter int nw = 27,
  parameter int dw = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [nw-1:0] num,
  input  logic [dw-1:0] den,
  output logic          done,
  output logic [nw-1:0] quo
);
  localparam int CW = (nw > 1) ? $clog2(nw) : 1;

  logic [nw-1:0] num_q;
  logic [dw-1:0] den_q;
  logic [dw:0]   rem;
  logic [dw:0]   trial;
  logic [dw:0]   rem_next;
  logic          q_bit;
  logic [CW-1:0] count;
  logic          busy;

  // Remainder stays below den, so its low dw bits plus the next numerator bit
  // form the trial value without loss.
  always_comb begin
    trial    = {rem[dw-1:0], num_q[nw-1]};
    q_bit    = (trial >= {1'b0, den_q});
    rem_next = q_bit ? (trial - {1'b0, den_q}) : trial;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q <= '0;
      den_q <= '0;
      rem   <= '0;
      quo   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        num_q <= num;
        den_q <= den;
        rem   <= '0;
        quo   <= '0;
        count <= CW'(nw - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        num_q <= {num_q[nw-2:0], 1'b0};
        rem   <= rem_next;
        quo   <= {quo[nw-2:0], q_bit};
        if (count == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/div_real_seq.sv
// Sequential signed fixed-point divider c = a / b with saturation and
// divide-by-zero handling around an unsigned restoring core.
module div_real_seq
  import svreal_div_pkg::*;
#(
  parameter int a_width    = 16,
  parameter int a_exponent = -8,
  parameter int b_width    = 17,
  parameter int b_exponent = -9,
  parameter int c_width    = 18,
  parameter int c_exponent = -10
) (
  input  logic           clk,
  input  logic           rst_n,
  div_real_seq_if.slave  bus,
  output state_t         dbg_state
);
  localparam int S  = calc_shift(a_exponent, b_exponent, c_exponent);
  localparam int NW = calc_nw(a_width, S);
  localparam int LW = ((NW > c_width) ? NW : c_width) + 1;

  localparam logic [c_width-1:0] C_MAX   = c_width'(sat_max(c_width));
  localparam logic [c_width-1:0] C_MIN   = c_width'(sat_min(c_width));
  localparam logic [LW-1:0]      POS_LIM = LW'(sat_max(c_width));
  localparam logic [LW-1:0]      NEG_LIM = LW'(-sat_min(c_width));

  if (S < 0) begin : g_bad_shift
    $error("div_real_seq: exponents give a negative alignment shift");
  end

  state_t             state_q, state_d;
  logic               accept, load_result;
  logic [a_width-1:0] abs_a;
  logic [b_width-1:0] abs_b;
  logic [NW-1:0]      num;
  logic               core_done;
  logic [NW-1:0]      core_quo;
  logic               neg_q, a_neg_q, bz_q, az_q;
  logic [c_width-1:0] c_q, c_d;
  logic               dz_q, dz_d, ovf_q, ovf_d;
  logic [LW-1:0]      q_ext, neg_mag;

  // Unsigned magnitudes: the most negative operand maps to 2^(w-1) exactly.
  assign abs_a = bus.a[a_width-1] ? $unsigned(-bus.a) : $unsigned(bus.a);
  assign abs_b = bus.b[b_width-1] ? $unsigned(-bus.b) : $unsigned(bus.b);
  assign num   = NW'(abs_a) << S;

  div_real_core #(.nw(NW), .dw(b_width)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .num   (num),
    .den   (abs_b),
    .done  (core_done),
    .quo   (core_quo)
  );

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = CALC;
      end
      CALC: if (core_done) begin
        load_result = 1'b1;
        state_d     = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_ext   = LW'(core_quo);
    neg_mag = -q_ext;
    c_d     = '0;
    dz_d    = 1'b0;
    ovf_d   = 1'b0;
    if (bz_q) begin
      dz_d = 1'b1;
      c_d  = az_q ? '0 : (a_neg_q ? C_MIN : C_MAX);
    end else if (neg_q) begin
      ovf_d = (q_ext > NEG_LIM);
      c_d   = ovf_d ? C_MIN : neg_mag[c_width-1:0];
    end else begin
      ovf_d = (q_ext > POS_LIM);
      c_d   = ovf_d ? C_MAX : q_ext[c_width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      bz_q    <= 1'b0;
      az_q    <= 1'b0;
      c_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        neg_q   <= bus.a[a_width-1] ^ bus.b[b_width-1];
        a_neg_q <= bus.a[a_width-1];
        bz_q    <= (bus.b == '0);
        az_q    <= (bus.a == '0);
      end
      if (load_result) begin
        c_q   <= c_d;
        dz_q  <= dz_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.c           = c_q;
  assign bus.div_by_zero = dz_q;
  assign bus.overflow    = ovf_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_div_real_seq.sv
// Bench for div_real_seq: reference model feeds an expected-result queue,
// results are popped and compared as the divider releases them.
module tb_div_real_seq;
  import svreal_div_pkg::*;

  localparam int A_W = 16, A_E = -8;
  localparam int B_W = 17, B_E = -9;
  localparam int C_W = 18, C_E = -10;
  localparam int SH  = A_E - B_E - C_E;
  localparam int LAT = A_W + SH + 1;
  localparam int RW  = C_W + 2;

  logic   clk = 1'b0;
  logic   rst_n;
  state_t dbg_state;
  int     n_tests = 0;
  int     n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_real_seq_if #(.a_width(A_W), .b_width(B_W), .c_width(C_W)) bus ();

  div_real_seq #(
    .a_width(A_W), .a_exponent(A_E), .b_width(B_W), .b_exponent(B_E),
    .c_width(C_W), .c_exponent(C_E)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed {c, div_by_zero, overflow}.
  function automatic logic [RW-1:0] model(input longint av, input longint bv);
    longint c_max, c_min, mag, val;
    logic   dz, ovf;
    c_max = (longint'(1) <<< (C_W - 1)) - 1;
    c_min = -c_max - 1;
    dz    = 1'b0;
    ovf   = 1'b0;
    if (bv == 0) begin
      dz  = 1'b1;
      val = (av > 0) ? c_max : ((av < 0) ? c_min : 0);
    end else begin
      mag = ((av < 0 ? -av : av) <<< SH) / (bv < 0 ? -bv : bv);
      val = ((av < 0) != (bv < 0)) ? -mag : mag;
      if (val > c_max) begin val = c_max; ovf = 1'b1; end
      if (val < c_min) begin val = c_min; ovf = 1'b1; end
    end
    return {C_W'(val), dz, ovf};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {bus.c, bus.div_by_zero, bus.overflow};
  endfunction

  // Drives one operation; hold = cycles of out_ready=0 after out_valid.
  task automatic do_op(input int av, input int bv, input int hold, input bit toggle);
    int            cnt;
    logic [RW-1:0] held;
    @(negedge clk);
    check("in_ready_before_op", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = A_W'(av);
    bus.b         = B_W'(bv);
    bus.out_ready = (hold == 0);
    exp_q.push_back(model(longint'(av), longint'(bv)));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    cnt = 0;
    do begin
      if (toggle) begin
        bus.a = A_W'($urandom);
        bus.b = B_W'($urandom);
      end
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.out_valid && cnt < 200);
    check("latency", 32'(cnt), 32'(LAT));
    if (!bus.out_valid) return;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      check("result", 32'(observed()), 32'(exp_q.pop_front()));
    end
    held = observed();
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_result", 32'(observed()), 32'(held));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 32'(bus.in_ready), 32'd1);
    check("release_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(observed()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(384, 256, 0, 1'b0);
    do_op(-384, 256, 0, 1'b0);
    do_op(256, 1536, 0, 1'b0);
    do_op(-256, 1536, 0, 1'b0);
    do_op(25600, 128, 0, 1'b0);
    do_op(-25600, 128, 0, 1'b0);
    do_op(-256, 0, 0, 1'b0);
    do_op(0, 0, 0, 1'b0);
    do_op(512, 0, 0, 1'b0);
    do_op(-32768, -65536, 0, 1'b0);
    do_op(-32768, 1, 0, 1'b0);
    do_op(384, 256, 5, 1'b0);
    do_op(-1000, 777, 3, 1'b1);

    // Reset in the middle of CALC, then a full-latency operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = A_W'(1000);
    bus.b        = B_W'(3);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("mid_calc_state", 32'(dbg_state), 32'(CALC));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(observed()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(-384, -256, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int ra, rb;
      ra = $signed(A_W'($urandom));
      rb = ($urandom_range(0, 5) == 0) ? 0 : int'($signed(B_W'($urandom_range(0, 131071))));
      do_op(ra, rb, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
